// File: rtl/axi4_sram_slave_if.sv
// axi4_if: AXI4 bus bundle (AW/W/B/AR/R) connecting a master to the SRAM slave.
interface axi4_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4
);
  logic [AXI4_ID_WIDTH-1:0]       awid;
  logic [AXI4_ADDRESS_WIDTH-1:0]  awaddr;
  logic [7:0]                     awlen;
  logic [2:0]                     awsize;
  logic [1:0]                     awburst;
  logic                           awvalid;
  logic                           awready;
  logic [AXI4_DATA_WIDTH-1:0]     wdata;
  logic [AXI4_DATA_WIDTH/8-1:0]   wstrb;
  logic                           wlast;
  logic                           wvalid;
  logic                           wready;
  logic [AXI4_ID_WIDTH-1:0]       bid;
  logic [1:0]                     bresp;
  logic                           bvalid;
  logic                           bready;
  logic [AXI4_ID_WIDTH-1:0]       arid;
  logic [AXI4_ADDRESS_WIDTH-1:0]  araddr;
  logic [7:0]                     arlen;
  logic [2:0]                     arsize;
  logic [1:0]                     arburst;
  logic                           arvalid;
  logic                           arready;
  logic [AXI4_ID_WIDTH-1:0]       rid;
  logic [AXI4_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                     rresp;
  logic                           rlast;
  logic                           rvalid;
  logic                           rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: AXI4 slave serving one burst at a time from an internal
// single-port SRAM of 2^MEM_ADDR_BITS bytes. Addresses alias modulo the memory size.
// Optional feature macro: AXI4_SRAM_SLAVE_WRAP_EN -- when defined, WRAP bursts wrap
// at (len+1)*2^size; when undefined, WRAP is treated exactly like INCR.
module axi4_sram_slave #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int MEM_ADDR_BITS      = 12
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  axi4_if.slave slave
);
  localparam int AW       = AXI4_ADDRESS_WIDTH;
  localparam int DW       = AXI4_DATA_WIDTH;
  localparam int STRB_W   = DW / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = MEM_ADDR_BITS - BYTE_LSB;
  localparam int DEPTH    = 2 ** IDX_W;
  localparam logic [2:0] MAX_SIZE    = 3'(BYTE_LSB);
  localparam logic [1:0] BURST_FIXED = 2'b00;
`ifdef AXI4_SRAM_SLAVE_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                   r_state;
  logic                     r_awready;
  logic                     r_wready;
  logic                     r_bvalid;
  logic                     r_arready;
  logic                     r_rvalid;
  logic                     r_rlast;
  logic                     r_rdFetch;
  logic                     r_prioWrite;
  logic [AXI4_ID_WIDTH-1:0] r_id;
  logic [AW-1:0]            r_addr;
  logic [7:0]               r_len;
  logic [7:0]               r_beat;
  logic [2:0]               r_size;
  logic [1:0]               r_burst;
  logic [DW-1:0]            r_rdata;
  logic [DW-1:0]            r_mem [DEPTH];

  logic [2:0]               w_sizeEff;
  logic [AW-1:0]            w_inc;
  logic [AW-1:0]            w_aligned;
  logic [AW-1:0]            w_nextAddr;
`ifdef AXI4_SRAM_SLAVE_WRAP_EN
  logic [AW-1:0]            w_wrapMask;
`endif
  logic [IDX_W-1:0]         w_idx;
  logic [IDX_W-1:0]         w_nextIdx;
  logic [7:0]               w_beatNext;
  logic                     w_wBeat;

  assign w_idx      = r_addr[MEM_ADDR_BITS-1:BYTE_LSB];
  assign w_nextIdx  = w_nextAddr[MEM_ADDR_BITS-1:BYTE_LSB];
  assign w_beatNext = r_beat + 8'd1;
  assign w_wBeat    = (r_state == WRITE) && r_wready && slave.wvalid;

  assign slave.awready = r_awready;
  assign slave.wready  = r_wready;
  assign slave.bvalid  = r_bvalid;
  assign slave.bid     = r_id;
  assign slave.bresp   = 2'b00;
  assign slave.arready = r_arready;
  assign slave.rvalid  = r_rvalid;
  assign slave.rlast   = r_rlast;
  assign slave.rid     = r_id;
  assign slave.rresp   = 2'b00;
  assign slave.rdata   = r_rdata;

  // Next beat address: oversized transfers clamp to the bus width, FIXED holds, INCR steps aligned
  always_comb begin
    w_sizeEff  = (r_size > MAX_SIZE) ? MAX_SIZE : r_size;
    w_inc      = AW'(1) << w_sizeEff;
    w_aligned  = r_addr & ~(w_inc - AW'(1));
    w_nextAddr = w_aligned + w_inc;
    if (r_burst == BURST_FIXED) begin
      w_nextAddr = r_addr;
    end
`ifdef AXI4_SRAM_SLAVE_WRAP_EN
    w_wrapMask = ((AW'(r_len) + AW'(1)) << w_sizeEff) - AW'(1);
    if (r_burst == BURST_WRAP) begin
      w_nextAddr = (r_addr & ~w_wrapMask) | (w_nextAddr & w_wrapMask);
    end
`endif
  end

  // RAM write port: each accepted W beat updates only its strobed bytes; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_wBeat) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (slave.wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= slave.wdata[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM: arbitrates AW/AR, sequences burst beats, and drives all handshake outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rdFetch   <= 1'b0;
      r_prioWrite <= 1'b1;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_awready) begin
            r_awready <= 1'b0;
            if (slave.awvalid) begin
              r_id        <= slave.awid;
              r_addr      <= slave.awaddr;
              r_len       <= slave.awlen;
              r_size      <= slave.awsize;
              r_burst     <= slave.awburst;
              r_beat      <= '0;
              r_wready    <= 1'b1;
              r_prioWrite <= 1'b0;
              r_state     <= WRITE;
            end
          end else if (r_arready) begin
            r_arready <= 1'b0;
            if (slave.arvalid) begin
              r_id        <= slave.arid;
              r_addr      <= slave.araddr;
              r_len       <= slave.arlen;
              r_size      <= slave.arsize;
              r_burst     <= slave.arburst;
              r_beat      <= '0;
              r_rdFetch   <= 1'b1;
              r_prioWrite <= 1'b1;
              r_state     <= READ;
            end
          end else if (slave.awvalid && (!slave.arvalid || r_prioWrite)) begin
            r_awready <= 1'b1;
          end else if (slave.arvalid) begin
            r_arready <= 1'b1;
          end
        end
        WRITE: begin
          if (w_wBeat) begin
            r_addr <= w_nextAddr;
            r_beat <= w_beatNext;
            if (r_beat == r_len) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (slave.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        READ: begin
          if (r_rdFetch) begin
            r_rdFetch <= 1'b0;
            r_rdata   <= r_mem[w_idx];
            r_rvalid  <= 1'b1;
            r_rlast   <= (r_len == 8'd0);
          end else if (slave.rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_addr  <= w_nextAddr;
              r_beat  <= w_beatNext;
              r_rdata <= r_mem[w_nextIdx];
              r_rlast <= (w_beatNext == r_len);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: directed vectors plus hand-written burst sequences for axi4_sram_slave.
module tb_axi4_sram_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MB = 12;

  typedef struct {
    logic [31:0] wAddr;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic [31:0] rAddr;
    logic [31:0] rExp;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] wrBuf [256];
  logic [31:0] rdBuf [256];
  logic [31:0] wrapAddr [4];
  vec_t        vecs [8];

  axi4_if #(.AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) bus ();

  axi4_sram_slave #(
    .AXI4_ADDRESS_WIDTH(AW),
    .AXI4_DATA_WIDTH(DW),
    .AXI4_ID_WIDTH(IW),
    .MEM_ADDR_BITS(MB)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .slave(bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic startAw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
  endtask

  task automatic startAr(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
  endtask

  task automatic finishAw();
    int n = 0;
    while (!bus.awready && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("awready", bus.awready, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic finishAr();
    int n = 0;
    while (!bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("arready", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic sendW(input int len, input logic [3:0] strb);
    for (int i = 0; i <= len; i++) begin
      bus.wdata = wrBuf[i]; bus.wstrb = strb; bus.wlast = (i == len); bus.wvalid = 1'b1;
      begin
        int n = 0;
        while (!bus.wready && n < 50) begin @(posedge clk); #1; n++; end
      end
      if (!bus.wready) begin
        checkOutput("wreadyTimeout", bus.wready, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic recvB(input logic [3:0] expId, input int delay);
    int n = 0;
    repeat (delay) begin @(posedge clk); #1; end
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("bvalid", bus.bvalid, 1'b1);
    checkOutput("bid", bus.bid, expId);
    checkOutput("bresp", bus.bresp, 2'b00);
    @(posedge clk); #1;
    bus.bready = 1'b0;
    checkOutput("bvalidEnd", bus.bvalid, 1'b0);
  endtask

  // Called at #1 after the AR handshake edge, i.e. already one cycle past the handshake cycle.
  task automatic recvR(input logic [3:0] expId, input int len, input bit toggle);
    int          lat    = 1;
    int          cycles = 0;
    int          beats  = 0;
    logic        rr     = 1'b1;
    logic        holdPend = 1'b0;
    logic [31:0] holdData = '0;
    logic        holdLast = 1'b0;
    bus.rready = 1'b0;
    while (!bus.rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    checkOutput("rLatency", lat, 2);
    while (beats <= len && cycles < 4 * len + 40) begin
      rr = toggle ? ~rr : 1'b1;
      bus.rready = rr;
      if (bus.rvalid) begin
        if (rr) begin
          rdBuf[beats] = bus.rdata;
          checkOutput("rid", bus.rid, expId);
          checkOutput("rresp", bus.rresp, 2'b00);
          checkOutput("rlast", bus.rlast, beats == len);
          beats++;
        end else begin
          holdPend = 1'b1; holdData = bus.rdata; holdLast = bus.rlast;
        end
      end
      @(posedge clk); #1;
      cycles++;
      if (holdPend) begin
        checkOutput("rHoldValid", bus.rvalid, 1'b1);
        checkOutput("rHoldData", bus.rdata, holdData);
        checkOutput("rHoldLast", bus.rlast, holdLast);
        holdPend = 1'b0;
      end
    end
    bus.rready = 1'b0;
    checkOutput("rBeats", beats, len + 1);
    if (!toggle) checkOutput("rBackToBack", cycles, len + 1);
    checkOutput("rvalidEnd", bus.rvalid, 1'b0);
  endtask

  task automatic writeBurst(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb);
    startAw(addr, id, 8'(len), size, burst);
    finishAw();
    sendW(len, strb);
    recvB(id, 0);
  endtask

  task automatic readBurst(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    startAr(addr, id, 8'(len), size, burst);
    finishAr();
    recvR(id, len, toggle);
  endtask

  task automatic applyStimulus(input int i);
    wrBuf[0] = vecs[i].wData;
    writeBurst(vecs[i].wAddr, 4'(i), 0, 3'd2, 2'b01, vecs[i].wStrb);
    readBurst(vecs[i].rAddr, 4'(i + 8), 0, 3'd2, 2'b01, 1'b0);
    checkOutput($sformatf("vec%0d", i), rdBuf[0], vecs[i].rExp);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF};
    vecs[1] = '{32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0000_0020, 32'hFF22_FF44};
    vecs[2] = '{32'h0000_0024, 32'h1234_5678, 4'hF, 32'h0000_0024, 32'h1234_5678};
    vecs[3] = '{32'h0000_0024, 32'hAABB_CCDD, 4'hA, 32'h0000_0024, 32'hAA34_CC78};
    vecs[4] = '{32'h0000_1028, 32'hCAFE_F00D, 4'hF, 32'h0000_0028, 32'hCAFE_F00D};
    vecs[5] = '{32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, 32'h0000_0FFC, 32'h0BAD_C0DE};
    vecs[6] = '{32'h0000_0030, 32'h0102_0304, 4'hF, 32'h0000_0030, 32'h0102_0304};
    vecs[7] = '{32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h8000_1030, 32'h0102_0304};

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values, sampled while reset is still held
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstHandshake", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 6'b0);
    checkOutput("rstIds", {bus.bid, bus.bresp, bus.rid, bus.rresp}, 12'h0);
    checkOutput("rstRdata", bus.rdata, 32'h0);
    doReset();

    // Arbitration straight out of reset: write first, then read on the next collision
    wrBuf[0] = 32'h0000_0077;
    startAw(32'h40, 4'd1, 8'd0, 3'd2, 2'b01);
    startAr(32'h40, 4'd2, 8'd0, 3'd2, 2'b01);
    begin
      int n = 0;
      while (!bus.awready && !bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    end
    checkOutput("arbFirst", {bus.awready, bus.arready}, 2'b10);
    finishAw();
    checkOutput("arreadyInWrite", bus.arready, 1'b0);
    sendW(0, 4'hF);
    recvB(4'd1, 0);
    wrBuf[0] = 32'h0000_0088;
    startAw(32'h44, 4'd3, 8'd0, 3'd2, 2'b01);
    begin
      int n = 0;
      while (!bus.awready && !bus.arready && n < 50) begin @(posedge clk); #1; n++; end
    end
    checkOutput("arbSecond", {bus.awready, bus.arready}, 2'b01);
    finishAr();
    recvR(4'd2, 0, 1'b0);
    checkOutput("arbReadData", rdBuf[0], 32'h0000_0077);
    finishAw();
    sendW(0, 4'hF);
    recvB(4'd3, 0);
    readBurst(32'h44, 4'd4, 0, 3'd2, 2'b01, 1'b0);
    checkOutput("arbWriteData", rdBuf[0], 32'h0000_0088);

    // Single write then read with delayed BREADY
    wrBuf[0] = 32'hDEAD_BEEF;
    startAw(32'h10, 4'd3, 8'd0, 3'd2, 2'b01);
    finishAw();
    sendW(0, 4'hF);
    recvB(4'd3, 2);
    readBurst(32'h10, 4'd3, 0, 3'd2, 2'b01, 1'b0);
    checkOutput("singleRead", rdBuf[0], 32'hDEAD_BEEF);

    // INCR 4-beat write, read back with RREADY toggling
    for (int i = 0; i < 4; i++) wrBuf[i] = 32'(i + 1);
    writeBurst(32'h100, 4'd6, 3, 3'd2, 2'b01, 4'hF);
    readBurst(32'h100, 4'd7, 3, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("incr4Beat%0d", i), rdBuf[i], 32'(i + 1));

    // Table of single-beat strobe/alias/boundary vectors
    for (int i = 0; i < 8; i++) applyStimulus(i);

    // FIXED burst: every beat lands on the same word
    wrBuf[0] = 32'd9; wrBuf[1] = 32'd8; wrBuf[2] = 32'd7;
    writeBurst(32'h80, 4'd5, 2, 3'd2, 2'b00, 4'hF);
    readBurst(32'h80, 4'd5, 2, 3'd2, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("fixedBeat%0d", i), rdBuf[i], 32'd7);

    // AxSIZE wider than the bus behaves as full width
    wrBuf[0] = 32'h1111_1111; wrBuf[1] = 32'h2222_2222;
    writeBurst(32'h90, 4'd2, 1, 3'd3, 2'b01, 4'hF);
    readBurst(32'h90, 4'd2, 1, 3'd2, 2'b01, 1'b0);
    checkOutput("oversize0", rdBuf[0], 32'h1111_1111);
    checkOutput("oversize1", rdBuf[1], 32'h2222_2222);

    // WRAP 4-beat read at 0x108 over a tagged region
    for (int i = 0; i < 6; i++) wrBuf[i] = 32'hA000_0100 + 32'(4 * i);
    writeBurst(32'h100, 4'd1, 5, 3'd2, 2'b01, 4'hF);
`ifdef AXI4_SRAM_SLAVE_WRAP_EN
    wrapAddr[0] = 32'h108; wrapAddr[1] = 32'h10C; wrapAddr[2] = 32'h100; wrapAddr[3] = 32'h104;
`else
    wrapAddr[0] = 32'h108; wrapAddr[1] = 32'h10C; wrapAddr[2] = 32'h110; wrapAddr[3] = 32'h114;
`endif
    readBurst(32'h108, 4'd9, 3, 3'd2, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("wrapBeat%0d", i), rdBuf[i], 32'hA000_0000 | wrapAddr[i]);

    // 256-beat burst, read back-to-back
    for (int i = 0; i < 256; i++) wrBuf[i] = 32'h3C00_0000 + 32'(i * 7);
    writeBurst(32'h400, 4'd10, 255, 3'd2, 2'b01, 4'hF);
    readBurst(32'h400, 4'd11, 255, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      if (rdBuf[i] !== 32'h3C00_0000 + 32'(i * 7)) checkOutput($sformatf("long%0d", i), rdBuf[i], 32'h3C00_0000 + 32'(i * 7));
    end
    checkOutput("longLast", rdBuf[255], 32'h3C00_0000 + 32'(255 * 7));

    // Reset during beat 2 of an 8-beat read, then a fresh read
    for (int i = 0; i < 8; i++) wrBuf[i] = 32'h5000_0000 + 32'(i);
    writeBurst(32'h200, 4'd12, 7, 3'd2, 2'b01, 4'hF);
    startAr(32'h200, 4'd13, 8'd7, 3'd2, 2'b01);
    finishAr();
    bus.rready = 1'b1;
    begin
      int n = 0;
      while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midBeat2", bus.rdata, 32'h5000_0002);
    rstn = 1'b0;
    #1;
    checkOutput("midRstValid", {bus.rvalid, bus.rlast, bus.arready}, 3'b000);
    checkOutput("midRstData", bus.rdata, 32'h0);
    bus.rready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    readBurst(32'h208, 4'd14, 0, 3'd2, 2'b01, 1'b0);
    checkOutput("afterRstRead", rdBuf[0], 32'h5000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
